// File: rtl/vga_timing_gen_module.sv
// vga_timing_gen_module: parametrised VGA sync/timing generator.
// A clock-enable divider produces one pixel tick every CLK_DIV clocks. Horizontal
// and vertical counters step on that tick through sync, back porch, active and
// front porch. All outputs are registered from the current counter values, so
// each output reflects the counters one CLK after they change.
// Optional build macro: VGA_FRAME_COUNT_EN adds a 16-bit wrapping frame counter
// output (Frame_Cnt_Sig).
module vga_timing_gen_module #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int CLK_DIV   = 4,
  parameter int SYNC_POL  = 0,
  parameter int LOOKAHEAD = 0,
  parameter int ADDR_W    = 11
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig,
  output logic              Ready_Sig,
  output logic              Pix_En_Sig,
  output logic              Line_Start_Sig,
  output logic              Frame_Start_Sig
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]       Frame_Cnt_Sig
`endif
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_VIS_BEG = H_SYNC + H_BACK;
  localparam int H_VIS_END = H_VIS_BEG + H_ACTIVE;
  localparam int V_VIS_BEG = V_SYNC + V_BACK;
  localparam int V_VIS_END = V_VIS_BEG + V_ACTIVE;

  // The horizontal width also covers the look-ahead position, which can run
  // past H_TOTAL-1 without wrapping (look-ahead never crosses a line).
  localparam int HW = $clog2(H_TOTAL + LOOKAHEAD + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic L_POL = (SYNC_POL != 0);

  logic [DW-1:0] r_div_cnt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic          r_hsync;
  logic          r_vsync;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_row;
  logic          r_ready;
  logic          r_pix_en;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_line_wrap;
  logic          w_frame_wrap;
  logic [HW-1:0] w_hp;
  logic          w_h_vis;
  logic          w_v_vis;
  logic          w_ready;
  logic [HW-1:0] w_col_full;
  logic [VW-1:0] w_row_full;

  // Decode tick, wrap events and the look-ahead visible window from the counters.
  always_comb begin
    w_tick       = (r_div_cnt == DW'(CLK_DIV - 1));
    w_h_last     = (r_h_cnt == HW'(H_TOTAL - 1));
    w_v_last     = (r_v_cnt == VW'(V_TOTAL - 1));
    w_line_wrap  = w_tick && w_h_last;
    w_frame_wrap = w_line_wrap && w_v_last;
    w_hp         = r_h_cnt + HW'(LOOKAHEAD);
    w_h_vis      = (w_hp >= HW'(H_VIS_BEG)) && (w_hp < HW'(H_VIS_END));
    w_v_vis      = (r_v_cnt >= VW'(V_VIS_BEG)) && (r_v_cnt < VW'(V_VIS_END));
    w_ready      = w_h_vis && w_v_vis;
    w_col_full   = w_hp - HW'(H_VIS_BEG);
    w_row_full   = r_v_cnt - VW'(V_VIS_BEG);
  end

  // Pixel-clock-enable divider and horizontal/vertical position counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
        if (w_h_last) begin
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end
      end
    end
  end

  // Registered outputs; the start strobes rise on the edge where the counters wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hsync       <= ~L_POL;
      r_vsync       <= ~L_POL;
      r_col         <= '0;
      r_row         <= '0;
      r_ready       <= 1'b0;
      r_pix_en      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (r_h_cnt < HW'(H_SYNC)) ? L_POL : ~L_POL;
      r_vsync       <= (r_v_cnt < VW'(V_SYNC)) ? L_POL : ~L_POL;
      r_col         <= w_ready ? ADDR_W'(w_col_full) : '0;
      r_row         <= w_ready ? ADDR_W'(w_row_full) : '0;
      r_ready       <= w_ready;
      r_pix_en      <= w_tick;
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign HSYNC_Sig       = r_hsync;
  assign VSYNC_Sig       = r_vsync;
  assign Column_Addr_Sig = r_col;
  assign Row_Addr_Sig    = r_row;
  assign Ready_Sig       = r_ready;
  assign Pix_En_Sig      = r_pix_en;
  assign Line_Start_Sig  = r_line_start;
  assign Frame_Start_Sig = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  // Frame counter steps on the same edge that raises Frame_Start_Sig; wraps naturally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign Frame_Cnt_Sig = r_frame_cnt;
`endif

endmodule
